// File: rtl/cache_way_array.sv
// Multi-way cache storage array: per-way byte-masked writes, registered read with
// write-first bypass, and a clear engine that zeroes every set after reset or flush.
module cache_way_array #(
    parameter int WIDTH    = 32,
    parameter int S_INDEX  = 3,
    parameter int NUM_WAYS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush_req,
    output logic                      ready,
    input  logic                      rd_en,
    input  logic [S_INDEX-1:0]        rindex,
    output logic [NUM_WAYS*WIDTH-1:0] rdata,
    output logic                      rvalid,
    input  logic [NUM_WAYS-1:0]       we,
    input  logic [S_INDEX-1:0]        windex,
    input  logic [WIDTH/8-1:0]        wmask,
    input  logic [WIDTH-1:0]          wdata
);
    localparam int NUM_SETS  = 2 ** S_INDEX;
    localparam int NUM_BYTES = WIDTH / 8;

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t               state;
    logic [S_INDEX-1:0]   clr_idx;
    logic [WIDTH-1:0]     mem [NUM_WAYS][NUM_SETS];
    logic [WIDTH-1:0]     wr_entry [NUM_WAYS];
    logic [NUM_WAYS*WIDTH-1:0] rd_next;

    function automatic logic [WIDTH-1:0] byte_merge(
        input logic [WIDTH-1:0]     old_v,
        input logic [WIDTH-1:0]     new_v,
        input logic [NUM_BYTES-1:0] mask
    );
        logic [WIDTH-1:0] r;
        r = old_v;
        for (int b = 0; b < NUM_BYTES; b++) begin
            if (mask[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

    assign ready = (state == IDLE);

    // Merged entry per way; a same-index read sees it for ways being written.
    always_comb begin
        rd_next = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            wr_entry[w] = byte_merge(mem[w][windex], wdata, wmask);
            rd_next[w*WIDTH +: WIDTH] = (we[w] && (rindex == windex)) ?
                                        wr_entry[w] : mem[w][rindex];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                for (int w = 0; w < NUM_WAYS; w++) mem[w][clr_idx] <= '0;
            end else begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    if (we[w]) mem[w][windex] <= wr_entry[w];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_idx <= '0;
            rvalid  <= 1'b0;
            rdata   <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    rvalid  <= 1'b0;
                    clr_idx <= clr_idx + 1'b1;
                    // Last set is written this cycle; clr_idx wraps back to 0.
                    if (&clr_idx) state <= IDLE;
                end
                IDLE: begin
                    rvalid <= rd_en;
                    if (rd_en) rdata <= rd_next;
                    if (flush_req) begin
                        state   <= CLEAR;
                        clr_idx <= '0;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_way_array.sv
// Randomised bench for cache_way_array: an array-level reference model checked every
// cycle, plus directed sequences with literal expected values.
module tb_cache_way_array;
    localparam int W  = 32;
    localparam int SI = 3;
    localparam int NW = 2;
    localparam int NS = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush_req = 1'b0;
    logic          ready;
    logic          rd_en = 1'b0;
    logic [SI-1:0] rindex = '0;
    logic [NW*W-1:0] rdata;
    logic          rvalid;
    logic [NW-1:0] we = '0;
    logic [SI-1:0] windex = '0;
    logic [W/8-1:0] wmask = '0;
    logic [W-1:0]  wdata = '0;

    int errors = 0;
    int checks = 0;

    cache_way_array #(.WIDTH(W), .S_INDEX(SI), .NUM_WAYS(NW)) dut (
        .clk(clk), .rst(rst), .flush_req(flush_req), .ready(ready),
        .rd_en(rd_en), .rindex(rindex), .rdata(rdata), .rvalid(rvalid),
        .we(we), .windex(windex), .wmask(wmask), .wdata(wdata)
    );

    always #5 clk = ~clk;

    // Reference model: whole-array contents plus a busy countdown after reset/flush.
    logic [W-1:0]    mdl_mem [NW][NS];
    logic [NW*W-1:0] mdl_rdata = '0;
    logic            mdl_rvalid = 1'b0;
    int              mdl_busy = 0;
    bit              started = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            started = 1'b1;
            mdl_busy = NS;
            mdl_rvalid = 1'b0;
            mdl_rdata = '0;
            for (int w = 0; w < NW; w++)
                for (int s = 0; s < NS; s++) mdl_mem[w][s] = '0;
        end else if (mdl_busy > 0) begin
            mdl_busy = mdl_busy - 1;
            mdl_rvalid = 1'b0;
        end else begin
            for (int w = 0; w < NW; w++) begin
                if (we[w]) begin
                    for (int b = 0; b < W/8; b++)
                        if (wmask[b]) mdl_mem[w][windex][8*b +: 8] = wdata[8*b +: 8];
                end
            end
            mdl_rvalid = rd_en;
            if (rd_en)
                for (int w = 0; w < NW; w++) mdl_rdata[w*W +: W] = mdl_mem[w][rindex];
            if (flush_req) begin
                mdl_busy = NS;
                for (int w = 0; w < NW; w++)
                    for (int s = 0; s < NS; s++) mdl_mem[w][s] = '0;
            end
        end
    end

    task automatic check(input string name, input logic [NW*W-1:0] act,
                         input logic [NW*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("ready", {63'd0, ready}, {63'd0, (mdl_busy == 0)});
            check("rvalid", {63'd0, rvalid}, {63'd0, mdl_rvalid});
            check("rdata", rdata, mdl_rdata);
        end
    end

    task automatic drive(input logic r, input logic [SI-1:0] ri, input logic [NW-1:0] w,
                         input logic [SI-1:0] wi, input logic [W/8-1:0] m,
                         input logic [W-1:0] d, input logic fl);
        rd_en = r; rindex = ri; we = w; windex = wi; wmask = m; wdata = d; flush_req = fl;
        @(posedge clk);
        #2;
        rd_en = 1'b0; we = '0; flush_req = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (!ready && n < 40) begin
            @(posedge clk);
            #2;
            n++;
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    int n;

    initial begin
        // Reset: exactly 8 not-ready cycles, then every set reads as zero.
        pulse_rst();
        count_busy(n);
        check("reset_busy_cycles", 64'(n), 64'd8);
        for (int s = 0; s < NS; s++) begin
            drive(1'b1, SI'(s), 2'b00, 3'd0, 4'h0, 32'h0, 1'b0);
            check("reset_read_data", rdata, 64'h0);
            check("reset_read_valid", {63'd0, rvalid}, 64'd1);
        end

        // Partial byte write into way 0.
        drive(1'b0, 3'd0, 2'b01, 3'd3, 4'hF, 32'h11223344, 1'b0);
        drive(1'b0, 3'd0, 2'b01, 3'd3, 4'b0011, 32'hAABBCCDD, 1'b0);
        drive(1'b1, 3'd3, 2'b00, 3'd0, 4'h0, 32'h0, 1'b0);
        check("byte_mask_write", rdata, {32'h0, 32'h1122CCDD});

        // Write-first bypass on way 1, way 0 shows stored value.
        drive(1'b0, 3'd0, 2'b01, 3'd5, 4'hF, 32'h55667788, 1'b0);
        drive(1'b1, 3'd5, 2'b10, 3'd5, 4'hF, 32'hDEADBEEF, 1'b0);
        check("bypass_data", rdata, {32'hDEADBEEF, 32'h55667788});
        check("bypass_valid", {63'd0, rvalid}, 64'd1);

        // Fill, flush, attempt writes and reads while clearing.
        for (int s = 0; s < NS; s++)
            drive(1'b0, 3'd0, 2'b11, SI'(s), 4'hF, $urandom() | 32'h1, 1'b0);
        drive(1'b0, 3'd0, 2'b00, 3'd0, 4'h0, 32'h0, 1'b1);
        for (int i = 0; i < NS; i++) begin
            check("flush_not_ready", {63'd0, ready}, 64'd0);
            drive(1'b1, SI'(i), 2'b11, SI'(i), 4'hF, $urandom() | 32'h1, 1'b0);
            check("read_while_busy_rvalid", {63'd0, rvalid}, 64'd0);
        end
        check("flush_ready_after", {63'd0, ready}, 64'd1);
        for (int s = 0; s < NS; s++) begin
            drive(1'b1, SI'(s), 2'b00, 3'd0, 4'h0, 32'h0, 1'b0);
            check("flush_read_zero", rdata, 64'h0);
        end

        // Reset in the middle of a clear restarts it from index 0.
        for (int s = 0; s < NS; s++)
            drive(1'b0, 3'd0, 2'b11, SI'(s), 4'hF, 32'hA5A50000 | 32'(s + 1), 1'b0);
        drive(1'b0, 3'd0, 2'b00, 3'd0, 4'h0, 32'h0, 1'b1);
        repeat (4) drive(1'b0, 3'd0, 2'b00, 3'd0, 4'h0, 32'h0, 1'b0);
        pulse_rst();
        count_busy(n);
        check("midclear_rst_busy", 64'(n), 64'd8);
        for (int s = 0; s < NS; s++) begin
            drive(1'b1, SI'(s), 2'b00, 3'd0, 4'h0, 32'h0, 1'b0);
            check("midclear_read_zero", rdata, 64'h0);
        end

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                pulse_rst();
            end else begin
                logic [SI-1:0] ri;
                ri = SI'($urandom_range(0, NS - 1));
                drive(1'($urandom_range(0, 1)), ri, NW'($urandom_range(0, 3)),
                      ($urandom_range(0, 2) == 0) ? ri : SI'($urandom_range(0, NS - 1)),
                      4'($urandom_range(0, 15)), $urandom(),
                      ($urandom_range(0, 59) == 0));
            end
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
